// File: rtl/buzzer_beep_module.sv
// rtl/buzzer_beep_module.sv - expands a one-cycle request into N timed square-wave beeps
// separated by silent gaps, with BUSY level and one-cycle DONE handshake back to the requester.
module buzzer_beep_module #(
   parameter int TONE_HALF = 25000,
   parameter int BEEP_LEN  = 5000000,
   parameter int GAP_LEN   = 2500000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BEEP_REQ,
   input  logic [2:0] BEEP_NUM,
   input  logic       BEEP_STOP,
   output logic       BUZZ,
   output logic       BUSY,
   output logic       DONE
);

   localparam int LEN_MAX = (BEEP_LEN > GAP_LEN) ? BEEP_LEN : GAP_LEN;
   localparam int LEN_W   = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
   localparam int TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

   localparam logic [LEN_W-1:0]  BEEP_LAST = LEN_W'(BEEP_LEN - 1);
   localparam logic [LEN_W-1:0]  GAP_LAST  = LEN_W'(GAP_LEN - 1);
   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TONE = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [2:0]         beeps_left, beeps_n;
   logic [TONE_W-1:0]  tone_cnt, tone_n;
   logic [LEN_W-1:0]   len_cnt, len_n;
   logic               buzz_n, busy_n, done_n;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         beeps_left <= '0;
         tone_cnt   <= '0;
         len_cnt    <= '0;
         BUZZ       <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         state      <= state_n;
         beeps_left <= beeps_n;
         tone_cnt   <= tone_n;
         len_cnt    <= len_n;
         BUZZ       <= buzz_n;
         BUSY       <= busy_n;
         DONE       <= done_n;
      end
   end

   // len_cnt is shared: it times the beep in TONE and the silence in GAP.
   always_comb begin
      state_n = state;
      beeps_n = beeps_left;
      tone_n  = tone_cnt;
      len_n   = len_cnt;
      buzz_n  = BUZZ;
      busy_n  = BUSY;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            buzz_n = 1'b0;
            busy_n = 1'b0;
            if (BEEP_REQ) begin
               if (BEEP_NUM != 3'd0) begin
                  state_n = TONE;
                  beeps_n = BEEP_NUM;
                  tone_n  = '0;
                  len_n   = '0;
                  buzz_n  = 1'b1;
                  busy_n  = 1'b1;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         TONE: begin
            if (BEEP_STOP) begin
               state_n = IDLE;
               beeps_n = '0;
               tone_n  = '0;
               len_n   = '0;
               buzz_n  = 1'b0;
               busy_n  = 1'b0;
            end else if (len_cnt == BEEP_LAST) begin
               beeps_n = beeps_left - 3'd1;
               tone_n  = '0;
               len_n   = '0;
               buzz_n  = 1'b0;
               if (beeps_left == 3'd1) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  state_n = GAP;
               end
            end else begin
               len_n = len_cnt + 1'b1;
               if (tone_cnt == TONE_LAST) begin
                  tone_n = '0;
                  buzz_n = ~BUZZ;
               end else begin
                  tone_n = tone_cnt + 1'b1;
               end
            end
         end
         GAP: begin
            buzz_n = 1'b0;
            if (BEEP_STOP) begin
               state_n = IDLE;
               beeps_n = '0;
               len_n   = '0;
               busy_n  = 1'b0;
            end else if (len_cnt == GAP_LAST) begin
               state_n = TONE;
               tone_n  = '0;
               len_n   = '0;
               buzz_n  = 1'b1;
            end else begin
               len_n = len_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            buzz_n  = 1'b0;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_buzzer_beep_module.sv
// tb/tb_buzzer_beep_module.sv - directed self-checking bench for buzzer_beep_module
// with TONE_HALF=2, BEEP_LEN=10, GAP_LEN=4.
module tb_buzzer_beep_module;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [2:0] num;
   logic       stop;
   logic       buzz, busy, done;

   int checks   = 0;
   int failures = 0;

   buzzer_beep_module #(.TONE_HALF(2), .BEEP_LEN(10), .GAP_LEN(4)) dut (
      .CLK      (clk),
      .RST      (rst),
      .BEEP_REQ (req),
      .BEEP_NUM (num),
      .BEEP_STOP(stop),
      .BUZZ     (buzz),
      .BUSY     (busy),
      .DONE     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; num = 3'd0; stop = 1'b0;
      tick(); tick();
      checks++;
      if ({buzz, busy, done} !== 3'b000) begin
         failures++; $display("FAIL reset_init: got buzz/busy/done=%b want 000", {buzz, busy, done});
      end
      rst = 1'b0;
      req = 1'b1; num = 3'd3;
      tick();
      req = 1'b0;
      tick(); tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL reset_pre_busy: got %b want 1", busy);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({buzz, busy, done} !== 3'b000) begin
         failures++; $display("FAIL reset_mid: got buzz/busy/done=%b want 000", {buzz, busy, done});
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({buzz, busy, done} !== 3'b000) begin
            failures++; $display("FAIL reset_after cyc%0d: got buzz/busy/done=%b want 000", i, {buzz, busy, done});
         end
      end
   endtask

   task automatic test_single_beep();
      int cnt;
      logic exp_buzz;
      req = 1'b1; num = 3'd1;
      tick();
      req = 1'b0; num = 3'd0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 60) begin
         exp_buzz = ((cnt / 2) % 2) == 0;
         checks++;
         if (buzz !== exp_buzz || done !== 1'b0) begin
            failures++; $display("FAIL single_pattern cyc%0d: got buzz=%b done=%b want buzz=%b done=0", cnt, buzz, done, exp_buzz);
         end
         cnt++;
         tick();
      end
      checks++;
      if (cnt != 10) begin
         failures++; $display("FAIL single_busy_len: got %0d want 10", cnt);
      end
      checks++;
      if (buzz !== 1'b0 || done !== 1'b1) begin
         failures++; $display("FAIL single_done: got buzz=%b done=%b want buzz=0 done=1", buzz, done);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL single_done_width: got %b want 0", done);
      end
   endtask

   task automatic test_triple_beep();
      int cnt, q;
      logic exp_buzz;
      req = 1'b1; num = 3'd3;
      tick();
      req = 1'b0; num = 3'd0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         q = cnt % 14;
         exp_buzz = (q < 10) ? (((q / 2) % 2) == 0) : 1'b0;
         checks++;
         if (buzz !== exp_buzz || done !== 1'b0) begin
            failures++; $display("FAIL triple_pattern cyc%0d: got buzz=%b done=%b want buzz=%b done=0", cnt, buzz, done, exp_buzz);
         end
         cnt++;
         tick();
      end
      checks++;
      if (cnt != 38) begin
         failures++; $display("FAIL triple_busy_len: got %0d want 38", cnt);
      end
      checks++;
      if (buzz !== 1'b0 || done !== 1'b1) begin
         failures++; $display("FAIL triple_done: got buzz=%b done=%b want buzz=0 done=1", buzz, done);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL triple_done_width: got %b want 0", done);
      end
   endtask

   task automatic test_zero_and_ignored();
      int cnt;
      req = 1'b1; num = 3'd0;
      tick();
      req = 1'b0;
      checks++;
      if ({buzz, busy, done} !== 3'b001) begin
         failures++; $display("FAIL zero_done: got buzz/busy/done=%b want 001", {buzz, busy, done});
      end
      tick();
      checks++;
      if ({buzz, busy, done} !== 3'b000) begin
         failures++; $display("FAIL zero_after: got buzz/busy/done=%b want 000", {buzz, busy, done});
      end
      req = 1'b1; num = 3'd1;
      tick();
      req = 1'b0; num = 3'd0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 60) begin
         if (cnt == 2) begin
            req = 1'b1; num = 3'd7;
         end else begin
            req = 1'b0; num = 3'd0;
         end
         cnt++;
         tick();
      end
      req = 1'b0;
      checks++;
      if (cnt != 10) begin
         failures++; $display("FAIL ignored_req_len: got %0d want 10", cnt);
      end
      checks++;
      if (done !== 1'b1) begin
         failures++; $display("FAIL ignored_req_done: got %b want 1", done);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL ignored_req_not_queued: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_abort();
      req = 1'b1; num = 3'd2;
      tick();
      req = 1'b0; num = 3'd0;
      for (int i = 0; i < 18; i++) tick();
      checks++;
      if (busy !== 1'b1 || buzz !== 1'b1) begin
         failures++; $display("FAIL abort_pre: got busy=%b buzz=%b want 1 1", busy, buzz);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if ({buzz, busy, done} !== 3'b000) begin
         failures++; $display("FAIL abort_stop: got buzz/busy/done=%b want 000", {buzz, busy, done});
      end
      req = 1'b1; num = 3'd1;
      tick();
      req = 1'b0; num = 3'd0;
      checks++;
      if (busy !== 1'b1 || buzz !== 1'b1 || done !== 1'b0) begin
         failures++; $display("FAIL abort_restart: got busy=%b buzz=%b done=%b want 1 1 0", busy, buzz, done);
      end
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         failures++; $display("FAIL abort_restart_done: got busy=%b done=%b want 0 1", busy, done);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int cnt;
      req = 1'b1; num = 3'd1;
      tick();
      req = 1'b0; num = 3'd0;
      for (int i = 0; i < 9; i++) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if ({buzz, busy, done} !== 3'b000) begin
         failures++; $display("FAIL stop_at_end: got buzz/busy/done=%b want 000", {buzz, busy, done});
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL stop_at_end_late_done: got %b want 0", done);
      end
      req = 1'b1; num = 3'd1; stop = 1'b1;
      tick();
      req = 1'b0; num = 3'd0; stop = 1'b0;
      checks++;
      if (busy !== 1'b1 || buzz !== 1'b1) begin
         failures++; $display("FAIL req_with_stop_idle: got busy=%b buzz=%b want 1 1", busy, buzz);
      end
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL b2b_last_tone: got busy=%b want 1", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         failures++; $display("FAIL b2b_done: got busy=%b done=%b want 0 1", busy, done);
      end
      req = 1'b1; num = 3'd2;
      tick();
      req = 1'b0; num = 3'd0;
      checks++;
      if (busy !== 1'b1 || buzz !== 1'b1 || done !== 1'b0) begin
         failures++; $display("FAIL b2b_accept: got busy=%b buzz=%b done=%b want 1 1 0", busy, buzz, done);
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 80) begin
         cnt++;
         tick();
      end
      checks++;
      if (cnt != 24 || done !== 1'b1) begin
         failures++; $display("FAIL b2b_second_len: got len=%0d done=%b want 24 1", cnt, done);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_beep();
      test_triple_beep();
      test_zero_and_ignored();
      test_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/buzzer_beep_module.md
Name: buzzer_beep_module

Overview:
- Output-side counterpart to the push-switch debouncer.
- The debouncer turns a long, noisy switch level into a single-cycle pulse. This block takes a single-cycle request pulse and expands it into a timed, audible buzzer pattern: N beeps of a square-wave tone separated by silent gaps.
- Sits between control logic (stopwatch start/stop/lap events) and the board buzzer pin.
- Reports BUSY and a one-cycle DONE pulse back to the requester.

Parameters:
TONE_HALF, 25000, clock cycles per half-period of the tone (1 kHz at 50 MHz CLK); legal range >=1
BEEP_LEN, 5000000, clock cycles per beep (100 ms at 50 MHz); legal range >=1
GAP_LEN, 2500000, clock cycles of silence between consecutive beeps (50 ms); legal range >=1

Ports:
CLK  input  1  system clock (50 MHz)
RST  input  1  synchronous, active-high reset
BEEP_REQ  input  1  one-cycle request pulse (e.g. debouncer PSW_SIG)
BEEP_NUM  input  3  number of beeps, 0-7; sampled only with an accepted BEEP_REQ
BEEP_STOP  input  1  abort the current pattern
BUZZ  output  1  buzzer drive (square wave during tone, 0 otherwise)
BUSY  output  1  pattern in progress
DONE  output  1  one-cycle pulse on normal pattern completion

Behaviour:
- Reset is synchronous (RST high at a CLK edge). Reset state: IDLE; BUZZ=0, BUSY=0, DONE=0; all counters 0. RST mid-pattern aborts it immediately with no DONE.
- All outputs are registered. Counters are sized with $clog2 of the largest parameter they must hold.
- State machine: IDLE, TONE, GAP. A register beeps_left (3 bits) holds the remaining beep count.
- IDLE behaviour:
  - BEEP_REQ=1 with BEEP_NUM>=1 is accepted: next state TONE, beeps_left=BEEP_NUM, tone/len counters cleared, BUSY=1, BUZZ=1 from the following cycle.
  - BEEP_REQ=1 with BEEP_NUM=0: stay IDLE, DONE=1 for one cycle, BUSY stays 0.
- TONE behaviour:
  - len counter counts 0..BEEP_LEN-1.
  - BUZZ toggles whenever the tone counter reaches TONE_HALF-1 (counter then wraps to 0). BUZZ starts at 1 in each beep.
  - At len counter = BEEP_LEN-1: BUZZ=0 next cycle and beeps_left decrements. If beeps_left was 1, go to IDLE with BUSY=0 and DONE=1 for one cycle. Otherwise go to GAP.
  - Each beep occupies exactly BEEP_LEN cycles.
- GAP behaviour:
  - BUZZ=0, BUSY=1.
  - Lasts exactly GAP_LEN cycles, then enters TONE with counters cleared and BUZZ=1.
- Timing totals:
  - BUSY high for exactly n*BEEP_LEN + (n-1)*GAP_LEN cycles.
  - DONE is asserted in the first cycle BUSY is 0.
- BEEP_REQ while BUSY=1 (TONE/GAP) is ignored, not queued.
- BEEP_STOP=1 in TONE or GAP: next cycle IDLE, BUZZ=0, BUSY=0, DONE=0. BEEP_STOP has priority over completion in the same cycle (no DONE). BEEP_STOP in IDLE has no effect.
- If BEEP_STOP and BEEP_REQ are both high in IDLE, the request is accepted (STOP only affects an active pattern).
- A request may be accepted on the cycle DONE is high, since state is IDLE by then. Back-to-back patterns are therefore separated by exactly one idle cycle.
- BUZZ never glitches; it is only a register output.

Test Plan (TONE_HALF=2, BEEP_LEN=10, GAP_LEN=4):
- Reset: assert RST for 2 cycles during an active TONE -> BUZZ=0, BUSY=0, DONE=0 the cycle after the first RST edge; no DONE after release.
- Single beep: BEEP_REQ pulse, BEEP_NUM=1 -> BUSY high exactly 10 cycles; BUZZ pattern 1,1,0,0,1,1,0,0,1,1; then BUZZ=0, DONE=1 for one cycle.
- Triple beep: BEEP_NUM=3 -> BUSY high 38 cycles (3*10+2*4); BUZZ=0 for 4 cycles in each of the two gaps; each beep restarts at BUZZ=1; one DONE at the end.
- Zero count and ignored request: BEEP_NUM=0 -> DONE pulse, BUSY and BUZZ stay 0. BEEP_REQ with BEEP_NUM=7 in the 3rd cycle of a 1-beep pattern -> total BUSY still 10 cycles.
- Abort: BEEP_STOP in cycle 5 of the 2nd beep of BEEP_NUM=2 -> BUZZ=0, BUSY=0 next cycle, no DONE. A new request is accepted on the following cycle.
- Stop at completion: BEEP_STOP on the last TONE cycle -> BUSY=0, DONE stays 0. A BEEP_REQ coinciding with DONE is accepted with BUSY=1 the next cycle.
